// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: memory map, screen geometry and screen reader state encoding.
// Screen reader latency: one cycle from read ack to stream byte; the stream stalls the fetch.
package chip8_pkg;

  localparam logic [11:0] MEM_FONT_BASE = 12'h050;
  localparam logic [11:0] MEM_PROG_BASE = 12'h200;
  localparam logic [11:0] MEM_TOP       = 12'hFFF;

  // Framebuffer occupies page 0x1xx of CPU memory.
  localparam logic [3:0]  SCR_BASE        = 4'h1;
  localparam int unsigned SCR_LINES       = 32;
  localparam int unsigned SCR_LINE_BYTES  = 8;
  localparam int unsigned SCR_FRAME_BYTES = SCR_LINES * SCR_LINE_BYTES;

  typedef enum logic [1:0] {
    SCR_IDLE = 2'd0,
    SCR_REQ  = 2'd1,
    SCR_OUT  = 2'd2
  } scr_state_e;

  function automatic logic [11:0] scr_addr(input logic [7:0] idx);
    return {SCR_BASE, idx};
  endfunction

endpackage

// File: rtl/scr_reader.sv
// Fetches one frame of screen bytes over the CPU screen port and streams them out with valid/ready.
// One read in flight; a stalled sink holds the current byte and blocks the next read.
module scr_reader
  import chip8_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = SCR_FRAME_BYTES,
  parameter logic [7:0]  FIRST_IDX   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       scr_busy,
  output logic       scr_read,
  output logic [7:0] scr_read_idx,
  input  logic [7:0] scr_read_byte,
  input  logic       scr_read_ack,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_idx,
  output logic       out_last,
  output logic       frame_done
);

  localparam logic [8:0] LAST_COUNT = 9'(FRAME_BYTES - 1);

  scr_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [8:0] count_q, count_d;
  logic [7:0] out_data_q, out_data_d;
  logic [7:0] out_idx_q, out_idx_d;
  logic       out_last_q, out_last_d;
  logic       frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    scr_read     = 1'b0;
    out_valid    = 1'b0;

    case (state_q)
      SCR_IDLE: begin
        // A start coinciding with the done pulse belongs to the frame just finished.
        if (start && !frame_done_q) begin
          idx_d   = FIRST_IDX;
          count_d = '0;
          state_d = SCR_REQ;
        end
      end
      SCR_REQ: begin
        scr_read = !scr_read_ack;
        if (scr_read_ack) begin
          out_data_d = scr_read_byte;
          out_idx_d  = idx_q;
          out_last_d = (count_q == LAST_COUNT);
          state_d    = SCR_OUT;
        end
      end
      SCR_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_last_q) begin
            frame_done_d = 1'b1;
            state_d      = SCR_IDLE;
          end else begin
            count_d = count_q + 9'd1;
            idx_d   = idx_q + 8'd1;
            state_d = SCR_REQ;
          end
        end
      end
      default: state_d = SCR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SCR_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign scr_busy     = (state_q != SCR_IDLE);
  assign scr_read_idx = idx_q;
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign out_last     = out_last_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_scr_reader.sv
// Directed bench for scr_reader: full frames, sink stall, held ack, start/ack filtering, reset abort, index wrap.
module tb_scr_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       scr_busy, scr_read, out_valid, out_last, frame_done;
  logic [7:0] scr_read_idx, out_data, out_idx;
  logic [7:0] scr_read_byte = 8'h00;
  logic       scr_read_ack = 1'b0;
  logic       out_ready = 1'b1;

  logic       start2 = 1'b0;
  logic       scr_busy2, scr_read2, out_valid2, out_last2, frame_done2;
  logic [7:0] scr_read_idx2, out_data2, out_idx2;
  logic [7:0] scr_read_byte2 = 8'h00;
  logic       scr_read_ack2 = 1'b0;
  logic       out_ready2 = 1'b1;

  scr_reader #(.FRAME_BYTES(256), .FIRST_IDX(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scr_busy(scr_busy),
    .scr_read(scr_read), .scr_read_idx(scr_read_idx), .scr_read_byte(scr_read_byte),
    .scr_read_ack(scr_read_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .frame_done(frame_done)
  );

  scr_reader #(.FRAME_BYTES(32), .FIRST_IDX(8'hF0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .scr_busy(scr_busy2),
    .scr_read(scr_read2), .scr_read_idx(scr_read_idx2), .scr_read_byte(scr_read_byte2),
    .scr_read_ack(scr_read_ack2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2), .frame_done(frame_done2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] scr_mem(input logic [7:0] i);
    return (i * 8'd37) ^ 8'hA5;
  endfunction

  // Responder for the main instance: ack 2 cycles into each read, 40 for hold_idx.
  int rsp_wait   = 0;
  int hold_idx   = -1;
  int stray_req  = 0;
  int stray_done = 0;
  always begin
    @(negedge clk);
    if (scr_read_ack) begin
      scr_read_ack = 1'b0;
    end else if (stray_req != stray_done) begin
      stray_done++;
      scr_read_ack  = 1'b1;
      scr_read_byte = 8'hEE;
    end else if (scr_read) begin
      if (rsp_wait >= ((int'(scr_read_idx) == hold_idx) ? 40 : 2)) begin
        scr_read_ack  = 1'b1;
        scr_read_byte = scr_mem(scr_read_idx);
        rsp_wait      = 0;
      end else begin
        rsp_wait++;
      end
    end else begin
      rsp_wait = 0;
    end
  end

  int rsp_wait2 = 0;
  always begin
    @(negedge clk);
    if (scr_read_ack2) begin
      scr_read_ack2 = 1'b0;
    end else if (scr_read2) begin
      if (rsp_wait2 >= 1) begin
        scr_read_ack2  = 1'b1;
        scr_read_byte2 = scr_mem(scr_read_idx2);
        rsp_wait2      = 0;
      end else begin
        rsp_wait2++;
      end
    end else begin
      rsp_wait2 = 0;
    end
  end

  // Stream monitor for the main instance.
  int   byte_cnt   = 0;
  int   done_total = 0;
  logic prev_busy  = 1'b0;
  logic lat_pend   = 1'b0;
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (!rst_n) begin
      byte_cnt  = 0;
      lat_pend  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (scr_busy && !prev_busy) byte_cnt = 0;
      if (lat_pend) check("lat_valid", 32'(out_valid), 32'd1);
      lat_pend = scr_read_ack && scr_busy && !out_valid;
      if (out_valid && out_ready) begin
        e = 8'(byte_cnt);
        check("acc_idx", 32'(out_idx), 32'(e));
        check("acc_data", 32'(out_data), 32'(scr_mem(e)));
        check("acc_last", 32'(out_last), 32'(byte_cnt == 255));
        byte_cnt++;
      end
      if (frame_done) done_total++;
      prev_busy = scr_busy;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(frame_done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(scr_busy),     32'd0);
    check({tag, "_read"},  32'(scr_read),     32'd0);
    check({tag, "_ridx"},  32'(scr_read_idx), 32'd0);
    check({tag, "_valid"}, 32'(out_valid),    32'd0);
    check({tag, "_data"},  32'(out_data),     32'd0);
    check({tag, "_oidx"},  32'(out_idx),      32'd0);
    check({tag, "_last"},  32'(out_last),     32'd0);
    check({tag, "_done"},  32'(frame_done),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    int c0;
    int k;
    logic [7:0] e;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    check("rst2_busy", 32'(scr_busy2), 32'd0);
    check("rst2_valid", 32'(out_valid2), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full frame, ready tied high.
    d0 = done_total;
    pulse_start();
    check("t1_busy", 32'(scr_busy), 32'd1);
    check("t1_read", 32'(scr_read), 32'd1);
    check("t1_ridx", 32'(scr_read_idx), 32'd0);
    wait_done("t1_done");
    check("t1_busy_at_done", 32'(scr_busy), 32'd0);
    check("t1_bytes", 32'(byte_cnt), 32'd256);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(frame_done), 32'd0);
    check("t1_busy_after", 32'(scr_busy), 32'd0);
    check("t1_done_cnt", 32'(done_total), 32'(d0 + 1));

    // Sink stall on idx 17, held ack on idx 40.
    hold_idx = 40;
    pulse_start();
    n = 0;
    while (!(out_valid && out_idx == 8'd17) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach", 32'(out_valid && out_idx == 8'd17), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx",   32'(out_idx),   32'd17);
      check("stall_data",  32'(out_data),  32'(scr_mem(8'd17)));
      check("stall_noread", 32'(scr_read), 32'd0);
      check("stall_busy",  32'(scr_busy),  32'd1);
    end
    @(negedge clk) out_ready = 1'b1;
    n = 0;
    while (!scr_read && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_next_ridx", 32'(scr_read_idx), 32'd18);
    check("stall_next_cnt", 32'(byte_cnt), 32'd18);

    n = 0;
    while (!(scr_read && scr_read_idx == 8'd40) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reach", 32'(scr_read && scr_read_idx == 8'd40), 32'd1);
    c0 = byte_cnt;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check("hold_read",  32'(scr_read),     32'd1);
      check("hold_ridx",  32'(scr_read_idx), 32'd40);
      check("hold_noval", 32'(out_valid),    32'd0);
    end
    n = 0;
    while (!(scr_read && scr_read_idx == 8'd41) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_one_byte", 32'(byte_cnt), 32'(c0 + 1));
    hold_idx = -1;
    wait_done("t2_done");
    check("t2_bytes", 32'(byte_cnt), 32'd256);

    // Start ignored mid-frame and alongside frame_done.
    @(posedge clk); #1;
    d0 = done_total;
    pulse_start();
    pulse_start();
    n = 0;
    while (byte_cnt != 100 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    n = 0;
    while (!(out_valid && out_idx == 8'd255) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t3_reach_last", 32'(out_valid && out_idx == 8'd255), 32'd1);
    start = 1'b1;
    @(negedge clk);
    check("t3_done", 32'(frame_done), 32'd1);
    @(posedge clk); #1;
    check("t3_idle_busy", 32'(scr_busy), 32'd0);
    check("t3_idle_read", 32'(scr_read), 32'd0);
    check("t3_done_once", 32'(frame_done), 32'd0);
    @(negedge clk) start = 1'b0;
    check("t3_bytes", 32'(byte_cnt), 32'd256);
    check("t3_done_cnt", 32'(done_total), 32'(d0 + 1));

    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    check("stray_busy",  32'(scr_busy),  32'd0);
    check("stray_valid", 32'(out_valid), 32'd0);
    check("stray_read",  32'(scr_read),  32'd0);

    // Reset mid-frame, then a fresh frame.
    pulse_start();
    n = 0;
    while (byte_cnt != 50 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    d0 = done_total;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    stray_req++;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy",  32'(scr_busy),   32'd0);
    check("abort_valid", 32'(out_valid),  32'd0);
    check("abort_nodone", 32'(done_total), 32'(d0));
    pulse_start();
    check("t4_read", 32'(scr_read), 32'd1);
    check("t4_ridx", 32'(scr_read_idx), 32'd0);
    wait_done("t4_done");
    check("t4_bytes", 32'(byte_cnt), 32'd256);

    // Wrapping index window on the second instance.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    check("wrap_first_ridx", 32'(scr_read_idx2), 32'hF0);
    k = 0;
    n = 0;
    while (!frame_done2 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (out_valid2) begin
        e = 8'hF0 + 8'(k);
        check("wrap_idx",  32'(out_idx2),  32'(e));
        check("wrap_data", 32'(out_data2), 32'(scr_mem(e)));
        check("wrap_last", 32'(out_last2), 32'(k == 31));
        k++;
      end
    end
    check("wrap_done", 32'(frame_done2), 32'd1);
    check("wrap_bytes", 32'(k), 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
